// File: rtl/soc_system_pio_out_pulse.sv
// soc_system_pio_out_pulse
// Avalon-MM output PIO with atomic set/clear and a retriggerable timed-pulse
// engine. A pulse inverts the selected output bits for PULSE_LEN cycles, then
// raises a sticky done flag that can drive a level interrupt.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   address[2:0]      word address (0 DATA, 1 OUTSET, 2 OUTCLR, 3 PULSE_LEN,
//                     4 PULSE, 5 STATUS, 6 IRQ_EN, 7 reserved)
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata[31:0]   write data; bits above the register width are ignored
//   readdata[31:0]    combinational, zero-extended read data
//   out_port[WIDTH]   data_out XOR pulse_mask
//   irq               done AND irq_en
module soc_system_pio_out_pulse #(
  parameter int unsigned      WIDTH           = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] PULSE_LEN_RESET = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic               done_q, done_d;
  logic               irq_en_q, irq_en_d;

  logic               wr, trig, done_set, done_clr;
  logic [WIDTH-1:0]   wd;
  logic               unused_wdata;

  // Only the low register-width bits of writedata are meaningful.
  assign unused_wdata = ^writedata;

  always_comb begin
    wr       = chipselect & ~write_n;
    wd       = writedata[WIDTH-1:0];
    data_d   = data_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    done_set = 1'b0;
    done_clr = 1'b0;

    if (wr) begin
      case (address)
        3'd0:    data_d   = wd;
        3'd1:    data_d   = data_q | wd;
        3'd2:    data_d   = data_q & ~wd;
        3'd3:    len_d    = writedata[CNT_W-1:0];
        3'd5:    done_clr = writedata[1];
        3'd6:    irq_en_d = writedata[0];
        default: ;
      endcase
    end

    // A trigger needs a nonzero mask and length; anything else is a no-op,
    // which also guarantees the counter is never loaded with zero.
    trig = wr && (address == 3'd4) && (wd != '0) && (len_q != '0);

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          mask_d  = wd;
          cnt_d   = len_q;
          state_d = S_ACTIVE;
        end
      end
      default: begin
        if (trig) begin
          // Retrigger: accumulate bits and restart the full length.
          mask_d = mask_q | wd;
          cnt_d  = len_q;
        end else if (cnt_q == CNT_W'(1)) begin
          mask_d   = '0;
          cnt_d    = '0;
          state_d  = S_IDLE;
          done_set = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase

    // Completion on the same edge as a W1C wins.
    done_d = (done_q & ~done_clr) | done_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      data_q   <= RESET_VALUE;
      mask_q   <= '0;
      cnt_q    <= '0;
      len_q    <= PULSE_LEN_RESET;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = data_q;
      3'd3:    readdata[CNT_W-1:0] = len_q;
      3'd4:    readdata[WIDTH-1:0] = mask_q;
      3'd5:    readdata[1:0]       = {done_q, state_q == S_ACTIVE};
      3'd6:    readdata[0]         = irq_en_q;
      default: ;
    endcase
  end

  assign out_port = data_q ^ mask_q;
  assign irq      = done_q & irq_en_q;

endmodule

// File: doc/soc_system_pio_out_pulse.md
Name: soc_system_pio_out_pulse

Overview:
- Parametrised Avalon-MM output PIO: next generation of the 2-bit control register block.
- Adds generic width, a configurable reset value, and atomic bit set/clear.
- Adds a retriggerable timed-pulse engine that inverts selected outputs for a programmed cycle count, with a sticky done flag and an interrupt.
- Sits on the HPS lightweight bridge and drives board-level control lines (LED/strobe/enable).

Parameters:
WIDTH, 2, output port width, legal 1..32
RESET_VALUE, 0, data_out value after reset (WIDTH bits)
CNT_W, 16, pulse length counter width, legal 1..32
PULSE_LEN_RESET, 1, PULSE_LEN register value after reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
address  in  3  word address
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data; bits above WIDTH ignored
readdata  out  32  combinational read data, zero-extended
out_port  out  WIDTH  data_out XOR pulse_mask
irq  out  1  done AND irq_en, registered-source level interrupt

Behaviour:
- Write strobe: wr = chipselect & ~write_n. All registers update on posedge clk. Reads are combinational from address, with zero wait states and no side effects.
- Register map (word address):
  - 0 DATA: RW; data_out <= writedata[WIDTH-1:0].
  - 1 OUTSET: W; data_out <= data_out | wd. Reads 0.
  - 2 OUTCLR: W; data_out <= data_out & ~wd. Reads 0.
  - 3 PULSE_LEN: RW, CNT_W bits.
  - 4 PULSE: W; trigger mask. Reads current pulse_mask.
  - 5 STATUS: bit0 busy (RO), bit1 done (sticky, W1C). Other bits 0.
  - 6 IRQ_EN: RW, bit0.
  - 7: reads 0; writes ignored.
- Reset (asynchronous assert, synchronous to clk on release): data_out=RESET_VALUE, pulse_mask=0, count=0, busy=0, done=0, irq_en=0, PULSE_LEN=PULSE_LEN_RESET. Therefore out_port=RESET_VALUE and irq=0.
- Pulse engine, states IDLE and ACTIVE (busy = ACTIVE).
  - IDLE: a PULSE write with nonzero mask and PULSE_LEN=N>0 loads pulse_mask <= mask, count <= N, and enters ACTIVE at that edge. out_port shows the inversion from the next cycle.
  - IDLE, mask=0 or N=0: no state change; done not set.
  - ACTIVE: count decrements each cycle. On the edge where count==1: pulse_mask <= 0, done <= 1, return to IDLE. Inverted bits are visible for exactly N cycles.
  - ACTIVE, PULSE write with nonzero mask and N>0 (retrigger): pulse_mask <= pulse_mask | mask, count <= N. Remaining time is discarded.
  - ACTIVE, PULSE write with mask=0 or N=0: ignored.
- PULSE_LEN write while ACTIVE affects only the next trigger.
- DATA/OUTSET/OUTCLR writes during ACTIVE modify data_out normally. out_port continues to apply the XOR.
- done: same-edge completion and W1C → set wins. A retrigger does not clear done.
- irq is combinational AND of registered done and irq_en. No glitch path from the bus.
- count is CNT_W bits. PULSE_LEN=2^CNT_W-1 is the maximum; no wrap because the load occurs only when N>0.
- Reset mid-pulse aborts immediately: out_port returns to RESET_VALUE asynchronously.

Test Plan:
- Reset with WIDTH=8, RESET_VALUE=8'hA5 → out_port=A5, readdata@0=A5, irq=0, readdata@3=1. Write DATA=0x1FF → out_port=FF.
- DATA=0x0F; OUTSET 0x30 → 0x3F; OUTCLR 0x05 → 0x3A. Reads @1/@2 return 0.
- PULSE_LEN=4, DATA=0x00, PULSE=0x81 → out_port=0x81 for exactly 4 cycles, then 0x00. STATUS reads 1 during the pulse and 2 after it. With IRQ_EN=1, irq rises on the same cycle busy falls. Writing STATUS=2 clears irq.
- PULSE_LEN=10, PULSE=0x01, then PULSE=0x02 after 6 cycles → out_port=0x03 for a further 10 cycles (16 total for bit 0), done set once.
- PULSE_LEN=0, PULSE=0xFF → out_port unchanged, busy=0, done=0. PULSE=0x00 with LEN=5 → no effect.
- Assert reset 2 cycles into an active 8-cycle pulse → out_port=RESET_VALUE immediately, busy=0, done=0 after release.
